// File: rtl/ysyx_22040750_imem_responder_pkg.sv
// Shared constants, FSM encoding and the fetch-range helper for the IF-side
// instruction memory responder.
package ysyx_22040750_imem_responder_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A fetch is bad when it is misaligned or falls outside the ROM window.
  // The offset subtraction wraps, so addresses below base land far out of range.
  function automatic logic fetch_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth_log2);
    logic [32:0] offset;
    logic [32:0] span;
    offset = {1'b0, addr - base};
    span   = 33'd1 << (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (offset >= span);
  endfunction

endpackage

// File: rtl/ysyx_22040750_imem_responder_if.sv
// Fetch handshake between the PC/IF stage (master) and the instruction
// memory responder (slave): valid/ready request, one-cycle response pulse.
interface ysyx_22040750_imem_responder_if;
  logic [31:0] I_addr;
  logic        I_addr_valid;
  logic        O_addr_ready;
  logic [31:0] O_inst;
  logic        O_inst_valid;
  logic        O_err;

  modport master (
    output I_addr, I_addr_valid,
    input  O_addr_ready, O_inst, O_inst_valid, O_err
  );

  modport slave (
    input  I_addr, I_addr_valid,
    output O_addr_ready, O_inst, O_inst_valid, O_err
  );
endinterface

// File: rtl/ysyx_22040750_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to draw per-request latencies.
module ysyx_22040750_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       I_sys_clk,
  input  logic       I_rst,
  output logic [7:0] lfsr
);

  // NOTE: reset is synchronous here, so I_rst is not in the sensitivity list.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

endmodule

// File: rtl/ysyx_22040750_imem_responder.sv
// Instruction memory responder: accepts one PC request at a time, reads the
// ROM after a fixed or pseudo-random latency and returns a one-cycle pulse.
module ysyx_22040750_imem_responder
  import ysyx_22040750_imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE,
  parameter int unsigned LATENCY    = 1,
  parameter bit          RAND_LAT   = 1'b0
) (
  input logic                           I_sys_clk,
  input logic                           I_rst,
  ysyx_22040750_imem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  if (LATENCY == 0) begin : g_bad_latency
    $error("ysyx_22040750_imem_responder: LATENCY must be at least 1");
  end

  state_e                state;
  logic [31:0]           addr_q;
  logic [LAT_W-1:0]      wait_cnt;
  logic [LAT_W-1:0]      lat;
  logic [7:0]            lfsr;
  logic                  accept;
  logic [31:0]           rd_addr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;
  logic [31:0]           rom [DEPTH];

  ysyx_22040750_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .I_sys_clk (I_sys_clk),
    .I_rst     (I_rst),
    .lfsr      (lfsr)
  );

  // NOTE: ready is combinational from state so a fetch can be accepted in the
  // same cycle a response goes out, giving one fetch per cycle at latency 1.
  assign bus.O_addr_ready = !I_rst && (state == ST_IDLE || state == ST_RESP);
  assign accept           = bus.I_addr_valid && bus.O_addr_ready;

  always_comb begin
    if (RAND_LAT) begin
      lat = LAT_W'(1 + (32'(lfsr & 8'h0F) % LATENCY));
    end else begin
      lat = LAT_W'(LATENCY);
    end
  end

  // The ROM is read on the edge entering RESP: from the live bus when a
  // latency-1 fetch is accepted, otherwise from the address latched at accept.
  assign rd_addr = (state == ST_WAIT) ? addr_q : bus.I_addr;
  assign rd_idx  = DEPTH_LOG2'((rd_addr - BASE_ADDR) >> 2);
  assign rd_err  = fetch_err(rd_addr, BASE_ADDR, DEPTH_LOG2);

  // NOTE: the ROM array carries no reset; its contents are preloaded image data.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state            <= ST_IDLE;
      addr_q           <= '0;
      wait_cnt         <= '0;
      bus.O_inst_valid <= 1'b0;
      bus.O_err        <= 1'b0;
      bus.O_inst       <= '0;
    end else begin
      bus.O_inst_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            addr_q <= bus.I_addr;
            if (lat == LAT_W'(1)) begin
              state            <= ST_RESP;
              bus.O_inst_valid <= 1'b1;
              bus.O_err        <= rd_err;
              bus.O_inst       <= rd_err ? NOP_INST : rom[rd_idx];
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= lat - LAT_W'(1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAT_W'(1)) begin
            state            <= ST_RESP;
            bus.O_inst_valid <= 1'b1;
            bus.O_err        <= rd_err;
            bus.O_inst       <= rd_err ? NOP_INST : rom[rd_idx];
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
